// File: rtl/pipe_hazard_ctrl.sv
// Pipelined control unit and hazard unit for a 5-stage MIPS core.
//
// The D-stage instruction fields are decoded into control bits. Those bits travel
// through the ID/EX, EX/MEM and MEM/WB control registers, next to the register
// addresses the hazard unit needs.
//
// The hazard unit provides the following:
//   - forwarding selects for the E-stage ALU operands and the D-stage branch compare
//   - a load-use stall
//   - a branch-compare stall
//   - a flush for a taken branch or jump
//   - a hold of E while a multicycle mult is in flight
//
// Parameters:
//   REG_AW  - register-address width
//   MUL_LAT - cycles a mult occupies E (>= 1; 1 means no extra stall)
//   FWD_EN  - 1 enables forwarding; 0 zeroes all forward selects and stalls on any RAW
//             hazard still in flight
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   opcode_d, funct_d   - instruction[31:26] and [5:0] of the D-stage instruction
//   rs_d, rt_d, rd_d    - D-stage register fields
//   equal_d             - datapath rs==rt compare (after D forwarding)
//   pc_src_d, jump_d    - take branch / take jump
//   stall_f, stall_d    - hold PC / hold IF/ID
//   flush_d, flush_e    - clear IF/ID / bubble into ID/EX
//   stall_e             - hold ID/EX while a mult is busy
//   forward_a_d/_b_d    - D-stage compare operand from M
//   forward_a_e/_b_e    - E-stage operand: 00 regfile, 10 M result, 01 W result
//   alu_control_e, alu_src_e, reg_dst_e, mul_e - E-stage datapath controls
//   mem_write_m         - data-memory write enable
//   reg_write_w, mem_to_reg_w - write-back controls
//   mul_busy            - multicycle counter active
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode_d,
  input  logic [5:0]        funct_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              equal_d,
  output logic              pc_src_d,
  output logic              jump_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              stall_e,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic [2:0]        alu_control_e,
  output logic              alu_src_e,
  output logic              reg_dst_e,
  output logic              mul_e,
  output logic              mem_write_m,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic              mul_busy
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnMult = 6'h18;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] FwdRf = 2'b00;
  localparam logic [1:0] FwdW  = 2'b01;
  localparam logic [1:0] FwdM  = 2'b10;

  // The counter only has to hold MUL_LAT-1.
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);

  // ---------------------------------------------------------------------------
  // D-stage decode
  // ---------------------------------------------------------------------------
  logic       reg_write_dec;
  logic       mem_to_reg_dec;
  logic       mem_write_dec;
  logic       alu_src_dec;
  logic       reg_dst_dec;
  logic       branch_dec;
  logic       jump_dec;
  logic       mul_dec;
  logic [2:0] alu_control_dec;

  // While reset is held, D is decoded as a nop, so no D-stage output can fire.
  always_comb begin
    reg_write_dec   = 1'b0;
    mem_to_reg_dec  = 1'b0;
    mem_write_dec   = 1'b0;
    alu_src_dec     = 1'b0;
    reg_dst_dec     = 1'b0;
    branch_dec      = 1'b0;
    jump_dec        = 1'b0;
    mul_dec         = 1'b0;
    alu_control_dec = AluAnd;
    if (!reset) begin
      unique case (opcode_d)
        OpRtype: begin
          unique case (funct_d)
            FnAdd: begin
              reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_control_dec = AluAdd;
            end
            FnSub: begin
              reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_control_dec = AluSub;
            end
            FnAnd: begin
              reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_control_dec = AluAnd;
            end
            FnOr: begin
              reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_control_dec = AluOr;
            end
            FnSlt: begin
              reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_control_dec = AluSlt;
            end
            FnMult:  mul_dec = 1'b1;
            default: ;
          endcase
        end
        OpLw: begin
          reg_write_dec   = 1'b1;
          alu_src_dec     = 1'b1;
          mem_to_reg_dec  = 1'b1;
          alu_control_dec = AluAdd;
        end
        OpSw: begin
          mem_write_dec   = 1'b1;
          alu_src_dec     = 1'b1;
          alu_control_dec = AluAdd;
        end
        OpBeq: begin
          branch_dec      = 1'b1;
          alu_control_dec = AluSub;
        end
        OpAddi: begin
          reg_write_dec   = 1'b1;
          alu_src_dec     = 1'b1;
          alu_control_dec = AluAdd;
        end
        OpJ:     jump_dec = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control registers
  // ---------------------------------------------------------------------------
  logic              reg_write_e;
  logic              mem_to_reg_e;
  logic              mem_write_e;
  logic [REG_AW-1:0] rs_e;
  logic [REG_AW-1:0] rt_e;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] write_reg_e;

  logic              reg_write_m;
  logic              mem_to_reg_m;
  logic [REG_AW-1:0] write_reg_m;

  logic [REG_AW-1:0] write_reg_w;

  logic [CntW-1:0]   mul_cnt;

  assign write_reg_e = reg_dst_e ? rd_e : rt_e;
  assign mul_busy    = (mul_cnt != '0);

  // ID/EX: a busy mult holds the register; otherwise a hazard inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      mem_write_e   <= 1'b0;
      alu_src_e     <= 1'b0;
      reg_dst_e     <= 1'b0;
      alu_control_e <= 3'b000;
      mul_e         <= 1'b0;
      rs_e          <= '0;
      rt_e          <= '0;
      rd_e          <= '0;
    end else if (!mul_busy) begin
      if (flush_e) begin
        reg_write_e   <= 1'b0;
        mem_to_reg_e  <= 1'b0;
        mem_write_e   <= 1'b0;
        alu_src_e     <= 1'b0;
        reg_dst_e     <= 1'b0;
        alu_control_e <= 3'b000;
        mul_e         <= 1'b0;
        rs_e          <= '0;
        rt_e          <= '0;
        rd_e          <= '0;
      end else begin
        reg_write_e   <= reg_write_dec;
        mem_to_reg_e  <= mem_to_reg_dec;
        mem_write_e   <= mem_write_dec;
        alu_src_e     <= alu_src_dec;
        reg_dst_e     <= reg_dst_dec;
        alu_control_e <= alu_control_dec;
        mul_e         <= mul_dec;
        rs_e          <= rs_d;
        rt_e          <= rt_d;
        rd_e          <= rd_d;
      end
    end
  end

  // EX/MEM: bubbles while the mult occupies E, so the held instruction leaves only once.
  always_ff @(posedge clk) begin
    if (reset || mul_busy) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      write_reg_m  <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_to_reg_m <= mem_to_reg_e;
      mem_write_m  <= mem_write_e;
      write_reg_m  <= write_reg_e;
    end
  end

  // MEM/WB
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      write_reg_w  <= '0;
    end else begin
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      write_reg_w  <= write_reg_m;
    end
  end

  // Mult occupancy: the mult stays in E for MUL_LAT cycles in total. The count holds
  // the cycles that remain after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (mul_busy) begin
      mul_cnt <= mul_cnt - CntW'(1);
    end else if (mul_dec && !flush_e) begin
      mul_cnt <= MulLoad;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A write to register 0 never creates a dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (dst != '0) && ((dst == a) || (dst == b));
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FwdRf;
    if (FWD_EN != 0 && src != '0) begin
      if (reg_write_m && write_reg_m == src) begin
        sel = FwdM;
      end else if (reg_write_w && write_reg_w == src) begin
        sel = FwdW;
      end
    end
    return sel;
  endfunction

  logic lw_stall;
  logic br_stall;
  logic raw_stall;
  logic haz_stall;

  always_comb begin
    lw_stall  = mem_to_reg_e && reg_hit(rt_e, rs_d, rt_d);
    br_stall  = branch_dec &&
                ((reg_write_e && reg_hit(write_reg_e, rs_d, rt_d)) ||
                 (mem_to_reg_m && reg_hit(write_reg_m, rs_d, rt_d)));
    // Without forwarding, any producer still in E or M must drain first.
    raw_stall = 1'b0;
    if (FWD_EN == 0) begin
      raw_stall = (reg_write_e && reg_hit(write_reg_e, rs_d, rt_d)) ||
                  (reg_write_m && reg_hit(write_reg_m, rs_d, rt_d));
    end
    haz_stall = lw_stall || br_stall || raw_stall;
  end

  // A busy mult already holds every upstream stage, so it masks bubbles and redirects.
  always_comb begin
    stall_f  = haz_stall || mul_busy;
    stall_d  = haz_stall || mul_busy;
    stall_e  = mul_busy;
    flush_e  = haz_stall && !mul_busy;
    pc_src_d = branch_dec && equal_d && !stall_d;
    jump_d   = jump_dec && !stall_d;
    flush_d  = pc_src_d || jump_d;
  end

  always_comb begin
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    if (FWD_EN != 0 && reg_write_m && write_reg_m != '0) begin
      forward_a_d = (write_reg_m == rs_d);
      forward_b_d = (write_reg_m == rt_d);
    end
    forward_a_e = fwd_sel_e(rs_e);
    forward_b_e = fwd_sel_e(rt_e);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. It drives two instances, one with MUL_LAT=4 and one with
// MUL_LAT=1, from the same D-stage stream.
//
// The reference model tracks the instruction occupying each stage as a decoded record.
// Every cycle it derives the expected outputs from the hazard rules and compares them
// with both DUTs.
//
// Directed sequences add literal expectations on top of the model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       asrc;
    logic       rdst;
    logic       mul;
    logic       br;
    logic       jmp;
    logic [2:0] alu;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic       pc_src;
    logic       jump;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       stall_e;
    logic       fad;
    logic       fbd;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic [2:0] alu;
    logic       asrc;
    logic       rdst;
    logic       mul;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic       busy;
  } out_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_d;
  logic [5:0] funct_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rd_d;
  logic       equal_d;
  out_t       act [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pc_src_d, jump_d, stall_f, stall_d, flush_d, flush_e, stall_e;
    logic       forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic [2:0] alu_control_e;
    logic       alu_src_e, reg_dst_e, mul_e, mem_write_m, reg_write_w, mem_to_reg_w;
    logic       mul_busy;

    pipe_hazard_ctrl #(
      .REG_AW (5),
      .MUL_LAT((g == 0) ? 4 : 1),
      .FWD_EN (1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .opcode_d     (opcode_d),
      .funct_d      (funct_d),
      .rs_d         (rs_d),
      .rt_d         (rt_d),
      .rd_d         (rd_d),
      .equal_d      (equal_d),
      .pc_src_d     (pc_src_d),
      .jump_d       (jump_d),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .stall_e      (stall_e),
      .forward_a_d  (forward_a_d),
      .forward_b_d  (forward_b_d),
      .forward_a_e  (forward_a_e),
      .forward_b_e  (forward_b_e),
      .alu_control_e(alu_control_e),
      .alu_src_e    (alu_src_e),
      .reg_dst_e    (reg_dst_e),
      .mul_e        (mul_e),
      .mem_write_m  (mem_write_m),
      .reg_write_w  (reg_write_w),
      .mem_to_reg_w (mem_to_reg_w),
      .mul_busy     (mul_busy)
    );

    assign act[g] = {pc_src_d, jump_d, stall_f, stall_d, flush_d, flush_e, stall_e,
                     forward_a_d, forward_b_d, forward_a_e, forward_b_e, alu_control_e,
                     alu_src_e, reg_dst_e, mul_e, mem_write_m, reg_write_w, mem_to_reg_w,
                     mul_busy};
  end

  int     checks;
  int     errors;
  bit     check_en;
  int     lat [2];
  instr_t cur_d;
  logic   cur_eq;
  logic   cur_rst;
  out_t   last_exp [2];

  // Model state: the instruction record in E, and what the M and W slots still carry.
  instr_t me  [2];
  logic [4:0] wm [2];
  logic [4:0] ww [2];
  logic rwm [2];
  logic m2rm [2];
  logic mwm [2];
  logic rww [2];
  logic m2rw [2];
  int   left [2];

  function automatic instr_t dec(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd);
    instr_t i;
    i = '0;
    i.rs = rs; i.rt = rt; i.rd = rd;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin i.rw = 1; i.rdst = 1; i.alu = 3'b010; end
          6'h22: begin i.rw = 1; i.rdst = 1; i.alu = 3'b110; end
          6'h24: begin i.rw = 1; i.rdst = 1; i.alu = 3'b000; end
          6'h25: begin i.rw = 1; i.rdst = 1; i.alu = 3'b001; end
          6'h2A: begin i.rw = 1; i.rdst = 1; i.alu = 3'b111; end
          6'h18: i.mul = 1;
          default: ;
        endcase
      end
      6'h23: begin i.rw = 1; i.asrc = 1; i.m2r = 1; i.alu = 3'b010; end
      6'h2B: begin i.mw = 1; i.asrc = 1; i.alu = 3'b010; end
      6'h04: begin i.br = 1; i.alu = 3'b110; end
      6'h08: begin i.rw = 1; i.asrc = 1; i.alu = 3'b010; end
      6'h02: i.jmp = 1;
      default: ;
    endcase
    return i;
  endfunction

  function automatic logic hits(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != 0) && (r == a || r == b);
  endfunction

  function automatic logic [1:0] fwd(input int k, input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (rwm[k] && wm[k] == r) return 2'b10;
    if (rww[k] && ww[k] == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input int k, input instr_t d, input logic eq,
                                     input logic rst);
    out_t o;
    instr_t dd;
    logic [4:0] wre;
    logic busy, lw, br, st;
    o  = '0;
    dd = d;
    if (rst) begin
      dd = '0; dd.rs = d.rs; dd.rt = d.rt; dd.rd = d.rd;
    end
    busy = (left[k] > 0);
    wre  = me[k].rdst ? me[k].rd : me[k].rt;
    lw   = me[k].m2r && hits(me[k].rt, dd.rs, dd.rt);
    br   = dd.br && ((me[k].rw && hits(wre, dd.rs, dd.rt)) ||
                     (m2rm[k] && hits(wm[k], dd.rs, dd.rt)));
    st   = lw || br || busy;
    o.stall_f = st;
    o.stall_d = st;
    o.stall_e = busy;
    o.flush_e = (lw || br) && !busy;
    o.pc_src  = dd.br && eq && !st;
    o.jump    = dd.jmp && !st;
    o.flush_d = o.pc_src || o.jump;
    o.fad     = rwm[k] && wm[k] != 0 && wm[k] == dd.rs;
    o.fbd     = rwm[k] && wm[k] != 0 && wm[k] == dd.rt;
    o.fae     = fwd(k, me[k].rs);
    o.fbe     = fwd(k, me[k].rt);
    o.alu     = me[k].alu;
    o.asrc    = me[k].asrc;
    o.rdst    = me[k].rdst;
    o.mul     = me[k].mul;
    o.mw      = mwm[k];
    o.rw      = rww[k];
    o.m2r     = m2rw[k];
    o.busy    = busy;
    return o;
  endfunction

  task automatic model_clear(input int k);
    me[k] = '0; wm[k] = '0; ww[k] = '0;
    rwm[k] = 0; m2rm[k] = 0; mwm[k] = 0; rww[k] = 0; m2rw[k] = 0;
    left[k] = 0;
  endtask

  // Advance the model by one clock edge, using the inputs and expectations of the cycle.
  task automatic model_step(input int k);
    if (cur_rst) begin
      model_clear(k);
    end else begin
      ww[k] = wm[k]; rww[k] = rwm[k]; m2rw[k] = m2rm[k];
      if (left[k] > 0) begin
        rwm[k] = 0; m2rm[k] = 0; mwm[k] = 0; wm[k] = '0;
        left[k] = left[k] - 1;
      end else begin
        rwm[k] = me[k].rw; m2rm[k] = me[k].m2r; mwm[k] = me[k].mw;
        wm[k]  = me[k].rdst ? me[k].rd : me[k].rt;
        if (last_exp[k].flush_e) begin
          me[k] = '0;
        end else begin
          me[k] = cur_d;
          if (cur_d.mul) left[k] = lat[k] - 1;
        end
      end
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic eq,
                       input logic rst);
    opcode_d = op; funct_d = fn; rs_d = rs; rt_d = rt; rd_d = rd; equal_d = eq;
    reset = rst;
    cur_d = dec(op, fn, rs, rt, rd); cur_eq = eq; cur_rst = rst;
    #4;
    for (int k = 0; k < 2; k++) begin
      last_exp[k] = model_out(k, cur_d, cur_eq, cur_rst);
      if (check_en) begin
        checks++;
        if (act[k] !== last_exp[k]) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t got %h exp %h", k, $time, act[k], last_exp[k]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  task automatic nop();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      tick();
    end
  endtask

  logic [5:0] r_op, r_fn;
  logic [4:0] r_rs, r_rt, r_rd;
  int         sel;
  logic       r_rst;

  initial begin
    checks = 0; errors = 0; check_en = 0;
    lat[0] = 4; lat[1] = 1;
    model_clear(0); model_clear(1);

    // Reset for two cycles with random D inputs.
    drive(6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
    tick();
    check_en = 1;
    drive(6'h04, 6'($urandom), 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
    lit("reset_zero_0", 32'(act[0]), 32'd0);
    lit("reset_zero_1", 32'(act[1]), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      nop();
      lit("nop_stream_zero", 32'(act[0]), 32'd0);
      tick();
    end

    // add $3,$1,$2 ; sub $4,$3,$5 -> forward from M
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); tick();
    drive(6'h00, 6'h22, 5'd3, 5'd5, 5'd4, 1'b0, 1'b0); tick();
    nop();
    lit("fwd_a_e_from_m", 32'(act[0].fae), 32'h2);
    lit("sub_alu_e", 32'(act[0].alu), 32'h6);
    tick();
    nops(3);

    // add ; nop ; sub -> forward from W
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); tick();
    nop(); tick();
    drive(6'h00, 6'h22, 5'd3, 5'd5, 5'd4, 1'b0, 1'b0); tick();
    nop();
    lit("fwd_a_e_from_w", 32'(act[0].fae), 32'h1);
    tick();
    nops(3);

    // addi $0 ; sub using $0 -> no forward
    drive(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h00, 6'h22, 5'd0, 5'd5, 5'd4, 1'b0, 1'b0); tick();
    nop();
    lit("fwd_reg0", 32'(act[0].fae), 32'h0);
    tick();
    nops(3);

    // lw $2,0($1) ; add $3,$2,$4 -> one load-use stall, then forward from W
    drive(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); tick();
    drive(6'h00, 6'h20, 5'd2, 5'd4, 5'd3, 1'b0, 1'b0);
    lit("lw_stall_f", 32'(act[0].stall_f), 32'h1);
    lit("lw_flush_e", 32'(act[0].flush_e), 32'h1);
    tick();
    drive(6'h00, 6'h20, 5'd2, 5'd4, 5'd3, 1'b0, 1'b0);
    lit("lw_stall_released", 32'(act[0].stall_d), 32'h0);
    tick();
    nop();
    lit("lw_fwd_a_e_w", 32'(act[0].fae), 32'h1);
    tick();
    nops(3);

    // add $2 ; beq $2,$3 taken -> branch stall, then D forward and redirect
    drive(6'h00, 6'h20, 5'd1, 5'd4, 5'd2, 1'b0, 1'b0); tick();
    drive(6'h04, 6'h00, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0);
    lit("br_stall_d", 32'(act[0].stall_d), 32'h1);
    lit("br_no_pc_src", 32'(act[0].pc_src), 32'h0);
    tick();
    drive(6'h04, 6'h00, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0);
    lit("br_fwd_a_d", 32'(act[0].fad), 32'h1);
    lit("br_pc_src", 32'(act[0].pc_src), 32'h1);
    lit("br_flush_d", 32'(act[0].flush_d), 32'h1);
    tick();
    nop();
    lit("br_pc_src_once", 32'(act[0].pc_src), 32'h0);
    tick();
    nops(3);

    // mult ; add -> three busy cycles on MUL_LAT=4, none on MUL_LAT=1
    drive(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
      lit("mul_busy_lat4", 32'(act[0].busy), 32'h1);
      lit("mul_stall_e_lat4", 32'(act[0].stall_e), 32'h1);
      lit("mul_busy_lat1", 32'(act[1].busy), 32'h0);
      tick();
    end
    drive(6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
    lit("mul_done", 32'(act[0].busy), 32'h0);
    lit("mul_still_e", 32'(act[0].mul), 32'h1);
    tick();
    nop();
    lit("add_in_e_after_mul", 32'({act[0].mul, act[0].alu}), 32'h2);
    tick();
    nops(3);

    // reset in the second busy cycle of a mult
    drive(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); tick();
    nop(); tick();
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); tick();
    nop();
    lit("mul_reset_zero", 32'(act[0]), 32'd0);
    tick();

    // j
    drive(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    lit("jump_d", 32'(act[0].jump), 32'h1);
    lit("jump_flush_d", 32'(act[0].flush_d), 32'h1);
    tick();
    nop();
    lit("jump_once", 32'(act[0].jump), 32'h0);
    tick();

    // Random stream. A stalled D re-presents its instruction; a flushed D becomes a nop.
    r_op = 0; r_fn = 0; r_rs = 0; r_rt = 0; r_rd = 0;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      if (!cur_rst && last_exp[0].stall_d) begin
        // keep current instruction
      end else if (!cur_rst && last_exp[0].flush_d) begin
        r_op = 0; r_fn = 0; r_rs = 0; r_rt = 0; r_rd = 0;
      end else begin
        sel  = $urandom_range(0, 13);
        r_fn = 6'($urandom);
        r_op = 6'h00;
        case (sel)
          0: r_fn = 6'h20;
          1: r_fn = 6'h22;
          2: r_fn = 6'h24;
          3: r_fn = 6'h25;
          4: r_fn = 6'h2A;
          5: r_fn = 6'h18;
          6: r_op = 6'h23;
          7: r_op = 6'h2B;
          8, 13: r_op = 6'h04;
          9: r_op = 6'h08;
          10: r_op = 6'h02;
          11: ;
          default: r_op = 6'h3F;
        endcase
        r_rs = 5'($urandom_range(0, 3));
        r_rt = 5'($urandom_range(0, 3));
        r_rd = 5'($urandom_range(0, 3));
      end
      drive(r_op, r_fn, r_rs, r_rt, r_rd, 1'($urandom_range(0, 1)), r_rst);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
